// File: rtl/fx2_stream_writer.sv
// Drains the DAQ output FIFO into an FX2 slave FIFO endpoint at one byte per four cycles,
// and commits any partial USB packet with PKTEND once the stream has been idle long enough.
module fx2_stream_writer #(
    parameter int         PKT_BYTES      = 512,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [1:0] EP_ADDR        = 2'b10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rdreq_o,
    input  logic [7:0]  fifo_data_i,
    input  logic        fx2_full_n_i,
    output logic        fx2_slwr_n_o,
    output logic        fx2_pktend_n_o,
    output logic [1:0]  fx2_fifoadr_o,
    output logic [7:0]  fx2_fd_o,
    output logic        busy_o,
    output logic [15:0] pkt_count_o
);

    localparam int              BCW       = $clog2(PKT_BYTES);
    localparam logic [BCW-1:0]  BYTE_LAST = BCW'(PKT_BYTES - 1);
    localparam logic [15:0]     IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_WAIT_FULL,
        ST_STROBE,
        ST_PEND_WAIT,
        ST_PEND
    } state_t;

    state_t         state_reg, state_next;
    logic [BCW-1:0] byte_cnt_reg, byte_cnt_next;
    logic [15:0]    idle_cnt_reg, idle_cnt_next;
    logic [15:0]    pkt_count_reg, pkt_count_next;
    logic [7:0]     fd_reg, fd_next;

    logic rdreq_reg;
    logic slwr_n_reg;
    logic pktend_n_reg;
    logic busy_reg;

    logic fetch_ok;

    assign fetch_ok = en_i && !fifo_empty_i;

    always_comb begin
        state_next     = state_reg;
        byte_cnt_next  = byte_cnt_reg;
        idle_cnt_next  = idle_cnt_reg;
        pkt_count_next = pkt_count_reg;
        fd_next        = fd_reg;

        case (state_reg)
            ST_IDLE: begin
                // New data wins over an expiring timeout.
                if (fetch_ok) begin
                    state_next    = ST_FETCH;
                    idle_cnt_next = '0;
                end else if (byte_cnt_reg != '0) begin
                    if (idle_cnt_reg == IDLE_LAST) begin
                        state_next = ST_PEND_WAIT;
                    end else begin
                        idle_cnt_next = idle_cnt_reg + 16'd1;
                    end
                end else begin
                    idle_cnt_next = '0;
                end
            end

            ST_FETCH: begin
                state_next = ST_LATCH;
            end

            ST_LATCH: begin
                fd_next    = fifo_data_i;
                state_next = ST_WAIT_FULL;
            end

            ST_WAIT_FULL: begin
                if (fx2_full_n_i) begin
                    state_next = ST_STROBE;
                end
            end

            ST_STROBE: begin
                // The FX2 commits a full packet on its own; only the count is tracked here.
                if (byte_cnt_reg == BYTE_LAST) begin
                    byte_cnt_next  = '0;
                    pkt_count_next = pkt_count_reg + 16'd1;
                end else begin
                    byte_cnt_next = byte_cnt_reg + BCW'(1);
                end
                state_next = fetch_ok ? ST_FETCH : ST_IDLE;
            end

            ST_PEND_WAIT: begin
                if (fx2_full_n_i) begin
                    state_next = ST_PEND;
                end
            end

            ST_PEND: begin
                byte_cnt_next  = '0;
                idle_cnt_next  = '0;
                pkt_count_next = pkt_count_reg + 16'd1;
                state_next     = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg     <= ST_IDLE;
            byte_cnt_reg  <= '0;
            idle_cnt_reg  <= '0;
            pkt_count_reg <= '0;
            fd_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            byte_cnt_reg  <= byte_cnt_next;
            idle_cnt_reg  <= idle_cnt_next;
            pkt_count_reg <= pkt_count_next;
            fd_reg        <= fd_next;
        end
    end

    // Strobes come straight from flops so the FX2 never sees a decode glitch.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rdreq_reg    <= 1'b0;
            slwr_n_reg   <= 1'b1;
            pktend_n_reg <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            rdreq_reg    <= (state_next == ST_FETCH);
            slwr_n_reg   <= (state_next != ST_STROBE);
            pktend_n_reg <= (state_next != ST_PEND);
            busy_reg     <= (state_next != ST_IDLE);
        end
    end

    assign fifo_rdreq_o   = rdreq_reg;
    assign fx2_slwr_n_o   = slwr_n_reg;
    assign fx2_pktend_n_o = pktend_n_reg;
    assign fx2_fifoadr_o  = EP_ADDR;
    assign fx2_fd_o       = fd_reg;
    assign busy_o         = busy_reg;
    assign pkt_count_o    = pkt_count_reg;

    a_strobes_exclusive: assert property (@(posedge clk_i) disable iff (!reset_i)
        !(!fx2_slwr_n_o && !fx2_pktend_n_o));

endmodule
